ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and the immediate generator.
- Keeps the fetch PC and issues word reads over a req/gnt/rvalid instruction-memory port.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/JALR) from execute, flushes in-flight work, and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding-plus-buffered fetches. Must be ≥2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  word-aligned fetch address.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid; responses return in order.
- imem_rdata_i  input  32  instruction word.
- redirect_i  input  1  flush and refetch.
- redirect_pc_i  input  32  new fetch PC.
- if_valid_o  output  1  head instruction valid to decode.
- id_ready_i  input  1  decode accepts head this cycle.
- if_instr_o  output  32  head instruction.
- if_pc_o  output  32  PC of head instruction.

Behaviour:
- Reset (async assert, sync release effect):
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc_o=0.
  - State: fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - First request rises in the first cycle after rst_i deasserts.
- imem_addr_o always equals the fetch PC; bits [1:0] are always 0.
- Issue rule: imem_req_o = !redirect_i && (outstanding + count − pop) < FIFO_DEPTH, where pop = if_valid_o && id_ready_i.
- Handshake:
  - Once raised, req/addr are held stable until gnt.
  - The only exception is a redirect: in the following cycle addr shows the new PC.
  - On req && gnt: fetch PC += 4 (wraps at 2^32, 32'hFFFF_FFFC → 0) and outstanding++.
- Response:
  - On rvalid with discard=0: push {fetch-order PC, rdata} to the FIFO tail and decrement outstanding.
  - rvalid with outstanding=0 is a protocol error; it is ignored and no state changes.
  - The PC for each response comes from an in-order queue of granted addresses, or equivalently a response-PC register advanced by 4.
- Latency:
  - gnt at cycle T, rvalid at T+1 → if_valid_o high at T+2. No bypass from rdata to the outputs.
  - With 1-cycle memory and id_ready_i held at 1, steady-state throughput is one instruction per cycle.
- Decode side:
  - if_valid_o = FIFO non-empty; it depends only on registered state.
  - if_instr_o/if_pc_o show the head entry and hold stable while if_valid_o && !id_ready_i.
  - They read 0 when the FIFO is empty.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - A full FIFO never overflows: the issue rule guarantees space.
- Redirect (redirect_i=1, single cycle):
  - Next edge: FIFO flushed (if_valid_o=0) and fetch PC = {redirect_pc_i[31:2], 2'b00}.
  - discard = outstanding + (req&&gnt this cycle) − (rvalid this cycle); outstanding is set to the same value.
  - imem_req_o is forced 0 in the redirect cycle, so no request is issued to the old path.
  - Any gnt seen that cycle belongs to a request presented earlier and counts as one to discard.
  - While discard>0, each rvalid decrements both discard and outstanding and writes nothing.
  - New requests may issue during discard, subject to the issue rule.
  - Back-to-back redirects: the later one wins; discard is recomputed by the same formula.
  - Decode's handshake in the redirect cycle is ignored for state purposes, since everything is flushed.
- Reset mid-operation: all state returns immediately to reset values; in-flight responses are not tracked.
- Counter width: $clog2(FIFO_DEPTH+1) for outstanding, discard, and count.

Test Plan:
- Reset then 1-cycle memory returning addr^32'hA5A5_0000, id_ready_i=1 → PCs 0,4,8,… with matching instrs; if_valid_o first high 2 cycles after the first gnt; one instruction per cycle thereafter.
- id_ready_i=0 for 6 cycles → FIFO fills to 2; imem_req_o drops with 0 outstanding; head holds PC 0 / instr stable; after release, PCs continue in order with none lost or duplicated.
- imem_gnt_i held 0 for 3 cycles with req high → imem_addr_o stays 0x0000_0000 and req stays high; PC advances only on the cycle gnt=1.
- 2 requests outstanding, redirect_i with redirect_pc_i=0x0000_0102 → both responses dropped; next request address 0x0000_0100; the first delivered PC is 0x100.
- Redirect in the same cycle as gnt and rvalid → discard counts the new gnt; no stale instruction ever reaches if_valid_o.
- Fetch PC 0xFFFF_FFF8, streaming → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst_i asserted mid-stream → outputs 0 and the first request after release goes to RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads on a req/gnt/rvalid
// port, buffers returned words with their PC and hands them to decode over valid/ready.
// Redirects flush the buffer and count in-flight responses so they can be dropped.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          req_pend_q;

    logic [31:0] buf_instr_q [FIFO_DEPTH];
    logic [31:0] buf_pc_q    [FIFO_DEPTH];

    logic          pop;
    logic          grant;
    logic          rsp_ok;
    logic          push;
    logic          late_gnt;
    logic [CW:0]   in_flight;
    logic [CW-1:0] redir_cnt;
    logic [31:0]   redir_pc;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and issue decisions
    always_comb begin
        if_valid_o  = (count_q != '0);
        if_instr_o  = if_valid_o ? buf_instr_q[rd_ptr_q] : 32'h0;
        if_pc_o     = if_valid_o ? buf_pc_q[rd_ptr_q] : 32'h0;
        imem_addr_o = fetch_pc_q;
        pop         = if_valid_o && id_ready_i;
        // Outstanding plus buffered, minus what leaves this cycle, must stay below depth
        in_flight   = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
        imem_req_o  = !rst_i && !redirect_i && (in_flight < (CW + 1)'(FIFO_DEPTH));
        grant       = imem_req_o && imem_gnt_i;
        // Responses with nothing outstanding are protocol errors and are ignored
        rsp_ok      = imem_rvalid_i && (outstanding_q != '0);
        push        = !redirect_i && rsp_ok && (discard_q == '0);
        // A gnt during a redirect acknowledges the request held up in the previous cycle
        late_gnt    = imem_gnt_i && req_pend_q;
        redir_cnt   = outstanding_q + CW'(late_gnt) - CW'(rsp_ok);
        redir_pc    = {redirect_pc_i[31:2], 2'b00};
    end

    // Next-state for PC, counters and buffer pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect_i) begin
            fetch_pc_d    = redir_pc;
            resp_pc_d     = redir_pc;
            outstanding_d = redir_cnt;
            discard_d     = redir_cnt;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_ok);
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = ptr_inc(wr_ptr_q);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            req_pend_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            req_pend_q    <= imem_req_o && !imem_gnt_i;
        end
    end

    // Buffer storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata_i;
            buf_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule
